// File: rtl/nios2_mult_pkg.sv
// Shared definitions for the Nios II pipelined multiplier: mode encodings,
// slice width and the stage-allocation helper.
package nios2_mult_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,
    MODE_MULXUU = 2'b01,
    MODE_MULXSU = 2'b10,
    MODE_MULXSS = 2'b11
  } mult_mode_e;

  // Stage 1 holds slice products and the last stage does correction, so the
  // adder tree gets whatever is left (zero means it merges into the last stage).
  function automatic int adder_stages(input int latency);
    return latency - 2;
  endfunction

endpackage

// File: rtl/nios2_mult_slice.sv
// 16x16 unsigned multiplier with a registered, enabled output; one per DSP block.
module nios2_mult_slice
  import nios2_mult_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [SLICE_W-1:0]     a,
  input  logic [SLICE_W-1:0]     b,
  output logic [2*SLICE_W-1:0]   prod
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod <= '0;
    end else if (en) begin
      prod <= {{SLICE_W{1'b0}}, a} * {{SLICE_W{1'b0}}, b};
    end
  end

endmodule

// File: rtl/nios2_mult_pipe.sv
// Stallable pipelined multiplier for the Nios II execute stage: slice products,
// a staged accumulation of partial products, then signed correction and half select.
module nios2_mult_pipe
  import nios2_mult_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result
);

  localparam int N          = DATA_W / SLICE_W;
  localparam int NP         = N * N;
  localparam int PW         = 2 * DATA_W;
  localparam int ADD_STAGES = adder_stages(LATENCY);
  localparam int CHUNK      = (ADD_STAGES > 0) ? (NP + ADD_STAGES - 1) / ADD_STAGES : NP;

  // One global enable: the whole pipe moves only when the output slot is free.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [2*SLICE_W-1:0] prod [NP];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      nios2_mult_slice u_slice (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv),
        .a       (src1[i*SLICE_W +: SLICE_W]),
        .b       (src2[j*SLICE_W +: SLICE_W]),
        .prod    (prod[i*N+j])
      );
    end
  end

  logic              s1_valid;
  mult_mode_e        s1_mode;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_MUL;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mode  <= mult_mode_e'(mode);
      s1_a     <= src1;
      s1_b     <= src2;
    end
  end

  // Product a_i*b_j carries weight 2^(16*(i+j)) in the full-width product.
  logic [PW-1:0] pp0 [NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      pp0[p] = '0;
      pp0[p][((p / N) + (p % N)) * SLICE_W +: 2*SLICE_W] = prod[p];
    end
  end

  // Stage k accumulates chunk k-1 of the partial products; products still
  // needed downstream ride along with the running sum.
  for (genvar k = 0; k <= ADD_STAGES; k++) begin : g_stage
    logic              valid;
    mult_mode_e        md;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [PW-1:0]     acc;

    if (k < ADD_STAGES) begin : g_pp
      logic [PW-1:0] pp [NP];
      if (k == 0) begin : g_first
        assign pp = pp0;
      end else begin : g_carry
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            pp <= '{default: '0};
          end else if (adv) begin
            pp <= g_stage[k-1].g_pp.pp;
          end
        end
      end
    end

    if (k == 0) begin : g_base
      assign valid = s1_valid;
      assign md    = s1_mode;
      assign a     = s1_a;
      assign b     = s1_b;
      assign acc   = '0;
    end else begin : g_add
      logic [PW-1:0] chunk_sum;

      always_comb begin
        chunk_sum = '0;
        for (int p = 0; p < NP; p++) begin
          if (p / CHUNK == k - 1) begin
            chunk_sum = chunk_sum + g_stage[k-1].g_pp.pp[p];
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid <= 1'b0;
          md    <= MODE_MUL;
          a     <= '0;
          b     <= '0;
          acc   <= '0;
        end else if (adv) begin
          valid <= g_stage[k-1].valid;
          md    <= g_stage[k-1].md;
          a     <= g_stage[k-1].a;
          b     <= g_stage[k-1].b;
          acc   <= g_stage[k-1].acc + chunk_sum;
        end
      end
    end
  end

  logic [PW-1:0] product;

  if (ADD_STAGES == 0) begin : g_merge
    always_comb begin
      product = g_stage[0].acc;
      for (int p = 0; p < NP; p++) begin
        product = product + pp0[p];
      end
    end
  end else begin : g_direct
    assign product = g_stage[ADD_STAGES].acc;
  end

  // Signed high halves come from the unsigned product by subtracting the
  // other operand wherever an operand is negative (mod 2^DATA_W).
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] corr_a;
  logic [DATA_W-1:0] corr_b;
  logic [DATA_W-1:0] result_d;

  always_comb begin
    hi       = product[PW-1:DATA_W];
    corr_a   = g_stage[ADD_STAGES].a[DATA_W-1] ? g_stage[ADD_STAGES].b : '0;
    corr_b   = g_stage[ADD_STAGES].b[DATA_W-1] ? g_stage[ADD_STAGES].a : '0;
    result_d = product[DATA_W-1:0];
    case (g_stage[ADD_STAGES].md)
      MODE_MUL:    result_d = product[DATA_W-1:0];
      MODE_MULXUU: result_d = hi;
      MODE_MULXSU: result_d = hi - corr_a;
      default:     result_d = hi - corr_a - corr_b;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (adv) begin
      out_valid <= g_stage[ADD_STAGES].valid;
      result    <= result_d;
    end
  end

endmodule

// File: doc/nios2_mult_pipe.md
# nios2_mult_pipe

Parametrised, stallable pipelined integer multiplier for the Nios II execute stage. It succeeds the fixed 32-bit, low-half-only multiplier cell. It supports configurable operand width and pipeline depth, plus all four Nios II multiply modes (MUL, MULXUU, MULXSU, MULXSS). It uses a valid/ready handshake so the ALU can back-pressure results.

## Interface
- DATA_W, 32: operand and result width; a multiple of 16, legal range 16–64.
- LATENCY, 3: cycles from an accepted input to out_valid; legal range 2–5.
- clk  in  1: single clock; all state on its rising edge.
- reset_n  in  1: asynchronous assert, active-low reset; clears the whole pipeline.
- in_valid  in  1: operand beat present.
- in_ready  out  1: pipeline can accept this cycle.
- src1  in  DATA_W: multiplicand (rA).
- src2  in  DATA_W: multiplier (rB).
- mode  in  2: 00 MUL (low half), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS; modes 01–11 return the high half.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts result.
- result  out  DATA_W: selected half of the 2·DATA_W product.

## Operation
- Operands are split into N = DATA_W/16 slices. The unsigned slice products a_i·b_j (N² of them) are registered in the first stage.
- Later stages sum the shifted partial products into an exact 2·DATA_W unsigned product P.
- Signed correction is applied in the final stage on the high half only, modulo 2^DATA_W:
  - MULXSU: high −= (src1 MSB ? src2 : 0).
  - MULXSS: high −= (src1 MSB ? src2 : 0) + (src2 MSB ? src1 : 0).
- MUL returns P[DATA_W-1:0]. It is identical for signed and unsigned operands.
- mode and the two operand MSBs travel down the pipe with the data.
- Every stage carries a valid bit. A global advance enable is `adv = !out_valid || out_ready`.
  - All stage registers, including the valid bits, update only when adv = 1.
  - in_ready = adv.
- An input beat is accepted when in_valid && in_ready.
- Bubbles are carried, not collapsed. Throughput is one result per cycle while out_ready = 1.
- While out_valid && !out_ready:
  - result and out_valid hold.
  - No stage advances.
  - in_ready = 0.

## Timing
- Reset (async, reset_n = 0):
  - All stage valid bits clear.
  - out_valid = 0 and result = 0.
  - in_ready = 1 once reset_n = 1, because out_valid = 0.
  - Data registers are also cleared, so no X appears on result.
- Reset mid-operation: in-flight beats are discarded and produce no out_valid after release.
- Latency: a beat accepted at edge k appears with out_valid = 1 after edge k+LATENCY−1, provided adv stayed 1. Each stalled cycle adds one cycle.
- Simultaneous events: a result consumed (out_ready = 1) and a new input accepted in the same cycle are both legal. Back-to-back beats produce back-to-back results.
- Stage allocation:
  - Stage 1: slice products.
  - Stages 2..LATENCY−1: the adder tree, split evenly.
  - Final stage: correction and half select.
- With LATENCY = 2, the adder tree and correction merge into stage 2.
- Arithmetic: all adds are exact to 2·DATA_W bits with no saturation. The correction wraps modulo 2^DATA_W.

## Structure
- Package nios2_mult_pkg holds:
  - mode encodings MODE_MUL, MODE_MULXUU, MODE_MULXSU, MODE_MULXSS.
  - SLICE_W = 16.
  - a function returning the number of adder stages for a given LATENCY.
- Sub-module nios2_mult_slice: a 16×16 unsigned multiplier with a registered output and an enable. It is instantiated N² times, maps one-to-one onto a DSP block, and has the same clk/reset_n.
- Top level: valid/enable control, adder-tree pipeline, correction, half select.

## Test plan
1. DATA_W=32, LATENCY=3; reset, then src1=0xFFFFFFFF, src2=0xFFFFFFFF in all four modes back to back -> results in order MUL=0x00000001, MULXUU=0xFFFFFFFE, MULXSU=0xFFFFFFFF, MULXSS=0x00000000; out_valid on four consecutive cycles starting 2 edges after the first accept.
2. src1=0x00010000, src2=0x00010000 -> MUL=0x00000000, MULXUU=0x00000001. src1=0x80000000, src2=0x80000000 -> MULXSS=0x40000000, MULXUU=0x40000000.
3. Back-pressure: hold out_ready=0 for 4 cycles while streaming 3 beats -> result frozen, in_ready=0 while out_valid=1, no beat lost or duplicated, order preserved on release.
4. Assert reset_n=0 with 2 beats in flight -> out_valid=0 and result=0 immediately (asynchronously); no spurious out_valid after release.
5. DATA_W=64, LATENCY=5: src1=0xFFFFFFFFFFFFFFFF, src2=0x2, MULXSU -> 0xFFFFFFFFFFFFFFFF; MULXUU -> 0x1; MUL -> 0xFFFFFFFFFFFFFFFE. Latency is 4 edges.
6. Random regression over all parameter sets and modes against a reference model, with random in_valid/out_ready -> bit-exact results, in order, with no drops.
